// File: rtl/rv32_alu_issue_ctrl.sv
// rtl/rv32_alu_issue_ctrl.sv - issue controller between decode and the two-cycle ALU execute FSM
//
// Purpose:
//   Accepts decoded ALU ops from decode, maps each op onto the engine's
//   2-bit select, starts the engine and waits for its data-valid. It then
//   captures result/carry, releases the engine hold and hands the final
//   result to writeback. SUB and SLTU use the engine adder with a negated
//   operand two.
//
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_issue_valid / o_issue_ready     decode handshake (ready only in IDLE)
//   i_issue_op                        000 ADD 001 SUB 010 AND 011 OR 100 XOR 101 SLTU
//   i_rs1_data, i_rs2_data, i_rd_addr operands and destination register
//   o_alu_start                       one-cycle engine start pulse
//   o_alu_operand_one/two, o_alu_sel  registered engine operands and select
//   o_alu_stall_reset                 clears the engine hold (RELEASE or timeout)
//   i_alu_data_valid, i_alu_result,
//   i_alu_carry_out                   engine response
//   o_wb_valid / i_wb_ready           writeback handshake
//   o_wb_rd_addr, o_wb_data, o_wb_carry  writeback payload
//   o_err_illegal, o_err_timeout      one-cycle error pulses

module rv32_alu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_issue_valid,
    output logic        o_issue_ready,
    input  logic [2:0]  i_issue_op,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [4:0]  i_rd_addr,
    output logic        o_alu_start,
    output logic [31:0] o_alu_operand_one,
    output logic [31:0] o_alu_operand_two,
    output logic [1:0]  o_alu_sel,
    output logic        o_alu_stall_reset,
    input  logic        i_alu_data_valid,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_carry_out,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [4:0]  o_wb_rd_addr,
    output logic [31:0] o_wb_data,
    output logic        o_wb_carry,
    output logic        o_err_illegal,
    output logic        o_err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3,
        S_WB      = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLTU = 3'd5;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [4:0]  r_rd;
    logic [2:0]  r_op;
    logic        r_rs2_nz;
    logic [31:0] r_result;
    logic        r_carry;
    logic [31:0] r_wb_data;
    logic        r_wb_carry;
    logic        r_err_illegal;
    logic [7:0]  r_cnt;

    logic        w_accept;
    logic        w_legal;
    logic        w_negate;
    logic        w_timeout;
    logic [7:0]  w_cnt_inc;

    assign w_accept  = (r_state == S_IDLE) && i_issue_valid;
    assign w_legal   = (i_issue_op[2:1] != 2'b11);
    assign w_negate  = (i_issue_op == OP_SUB) || (i_issue_op == OP_SLTU);
    assign w_cnt_inc = r_cnt + 8'd1;
    // The cycle in which the count reaches the limit is itself the abort
    // cycle; a data-valid arriving in that same cycle takes priority.
    assign w_timeout = (r_state == S_WAIT) && !i_alu_data_valid
                       && (w_cnt_inc == TIMEOUT_LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_op1         <= '0;
            r_op2         <= '0;
            r_rd          <= '0;
            r_op          <= '0;
            r_rs2_nz      <= 1'b0;
            r_result      <= '0;
            r_carry       <= 1'b0;
            r_wb_data     <= '0;
            r_wb_carry    <= 1'b0;
            r_err_illegal <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_next;
            r_err_illegal <= w_accept && !w_legal;

            if (w_accept && w_legal) begin
                r_op1    <= i_rs1_data;
                r_op2    <= w_negate ? (~i_rs2_data + 32'd1) : i_rs2_data;
                r_rd     <= i_rd_addr;
                r_op     <= i_issue_op;
                // Negating zero gives zero, so the adder carry alone cannot
                // tell SLTU that rs2 was zero; remember it explicitly.
                r_rs2_nz <= |i_rs2_data;
            end

            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= w_cnt_inc;
            end

            if ((r_state == S_WAIT) && i_alu_data_valid) begin
                r_result <= i_alu_result;
                r_carry  <= i_alu_carry_out;
            end

            if (r_state == S_RELEASE) begin
                if (r_op == OP_SLTU) begin
                    // rs1 + (-rs2) carries out exactly when rs1 >= rs2 (rs2 != 0)
                    r_wb_data <= {31'd0, r_rs2_nz && !r_carry};
                end else begin
                    r_wb_data <= r_result;
                end
                r_wb_carry <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? r_carry : 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        o_issue_ready     = 1'b0;
        o_alu_start       = 1'b0;
        o_alu_stall_reset = 1'b0;
        o_wb_valid        = 1'b0;
        o_err_timeout     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_issue_ready = 1'b1;
                if (w_accept && w_legal) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_alu_start  = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_alu_data_valid) begin
                    w_state_next = S_RELEASE;
                end else if (w_timeout) begin
                    o_err_timeout     = 1'b1;
                    o_alu_stall_reset = 1'b1;
                    w_state_next      = S_IDLE;
                end
            end
            S_RELEASE: begin
                o_alu_stall_reset = 1'b1;
                w_state_next      = S_WB;
            end
            S_WB: begin
                o_wb_valid = 1'b1;
                if (i_wb_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_alu_sel = 2'b00;
        case (r_op)
            OP_AND:  o_alu_sel = 2'b01;
            OP_OR:   o_alu_sel = 2'b10;
            OP_XOR:  o_alu_sel = 2'b11;
            default: o_alu_sel = 2'b00;
        endcase
    end

    assign o_alu_operand_one = r_op1;
    assign o_alu_operand_two = r_op2;
    assign o_wb_rd_addr      = r_rd;
    assign o_wb_data         = r_wb_data;
    assign o_wb_carry        = r_wb_carry;
    assign o_err_illegal     = r_err_illegal;

endmodule

// File: tb/tb_rv32_alu_issue_ctrl.sv
// tb/tb_rv32_alu_issue_ctrl.sv - self-checking bench for rv32_alu_issue_ctrl

module tb_rv32_alu_issue_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_issue_valid;
    logic        o_issue_ready;
    logic [2:0]  i_issue_op;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [4:0]  i_rd_addr;
    logic        o_alu_start;
    logic [31:0] o_alu_operand_one;
    logic [31:0] o_alu_operand_two;
    logic [1:0]  o_alu_sel;
    logic        o_alu_stall_reset;
    logic        i_alu_data_valid;
    logic [31:0] i_alu_result;
    logic        i_alu_carry_out;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic [4:0]  o_wb_rd_addr;
    logic [31:0] o_wb_data;
    logic        o_wb_carry;
    logic        o_err_illegal;
    logic        o_err_timeout;

    always #5 i_clk = ~i_clk;

    rv32_alu_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_issue_valid     (i_issue_valid),
        .o_issue_ready     (o_issue_ready),
        .i_issue_op        (i_issue_op),
        .i_rs1_data        (i_rs1_data),
        .i_rs2_data        (i_rs2_data),
        .i_rd_addr         (i_rd_addr),
        .o_alu_start       (o_alu_start),
        .o_alu_operand_one (o_alu_operand_one),
        .o_alu_operand_two (o_alu_operand_two),
        .o_alu_sel         (o_alu_sel),
        .o_alu_stall_reset (o_alu_stall_reset),
        .i_alu_data_valid  (i_alu_data_valid),
        .i_alu_result      (i_alu_result),
        .i_alu_carry_out   (i_alu_carry_out),
        .o_wb_valid        (o_wb_valid),
        .i_wb_ready        (i_wb_ready),
        .o_wb_rd_addr      (o_wb_rd_addr),
        .o_wb_data         (o_wb_data),
        .o_wb_carry        (o_wb_carry),
        .o_err_illegal     (o_err_illegal),
        .o_err_timeout     (o_err_timeout)
    );

    // Two-cycle engine: data-valid two cycles after the start pulse.
    logic        eng_en;
    logic [1:0]  eng_dly;
    logic [32:0] eng_sum;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            eng_dly <= 2'd0;
        end else if (o_alu_start) begin
            eng_dly <= 2'd2;
        end else if (eng_dly != 2'd0) begin
            eng_dly <= eng_dly - 2'd1;
        end
    end

    always_comb begin
        eng_sum = {1'b0, o_alu_operand_one} + {1'b0, o_alu_operand_two};
        case (o_alu_sel)
            2'b01:   begin i_alu_result = o_alu_operand_one & o_alu_operand_two; i_alu_carry_out = 1'b0; end
            2'b10:   begin i_alu_result = o_alu_operand_one | o_alu_operand_two; i_alu_carry_out = 1'b0; end
            2'b11:   begin i_alu_result = o_alu_operand_one ^ o_alu_operand_two; i_alu_carry_out = 1'b0; end
            default: begin i_alu_result = eng_sum[31:0]; i_alu_carry_out = eng_sum[32]; end
        endcase
    end

    assign i_alu_data_valid = eng_en && (eng_dly == 2'd1);

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] exp_op2;
        logic [1:0]  exp_sel;
        logic [31:0] exp_data;
        logic        exp_carry;
        int          hold;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        carry;
    } wb_t;

    wb_t  sb[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        wb_t e;
        wb_t got;
        int  n_start;
        int  n_stall;
        int  lat;
        bit  ok;
        n_start = 0;
        n_stall = 0;
        lat     = 0;
        ok      = 1'b0;
        e.rd    = v.rd;
        e.data  = v.exp_data;
        e.carry = v.exp_carry;
        sb.push_back(e);

        @(posedge i_clk); #1;
        i_issue_valid = 1'b1;
        i_issue_op    = v.op;
        i_rs1_data    = v.rs1;
        i_rs2_data    = v.rs2;
        i_rd_addr     = v.rd;
        @(negedge i_clk);
        check("issue_ready_at_accept", o_issue_ready, 1);
        @(posedge i_clk); #1;
        i_issue_valid = 1'b0;

        for (int c = 1; c <= 40; c++) begin
            @(negedge i_clk);
            if (o_alu_start) begin
                n_start++;
                check("alu_operand_one", o_alu_operand_one, v.rs1);
                check("alu_operand_two", o_alu_operand_two, v.exp_op2);
                check("alu_sel", o_alu_sel, v.exp_sel);
            end
            if (o_alu_stall_reset) n_stall++;
            if (o_wb_valid) begin
                lat = c;
                ok  = 1'b1;
                break;
            end
        end
        got = sb.pop_front();
        check("wb_valid_seen", ok, 1);
        if (!ok) return;
        check("latency", lat, 5);
        check("start_pulses", n_start, 1);
        check("stall_reset_pulses", n_stall, 1);

        for (int h = 0; h <= v.hold; h++) begin
            if (h > 0) @(negedge i_clk);
            check("wb_valid_held", o_wb_valid, 1);
            check("issue_ready_in_wb", o_issue_ready, 0);
            check("wb_rd", o_wb_rd_addr, got.rd);
            check("wb_data", o_wb_data, got.data);
            check("wb_carry", o_wb_carry, got.carry);
        end
        @(posedge i_clk); #1;
        i_wb_ready = 1'b1;
        @(negedge i_clk);
        check("wb_data_at_handshake", o_wb_data, got.data);
        @(posedge i_clk); #1;
        i_wb_ready = 1'b0;
        @(negedge i_clk);
        check("wb_valid_after_handshake", o_wb_valid, 0);
        check("issue_ready_after_wb", o_issue_ready, 1);
    endtask

    initial begin
        int n_ill;
        int n_start;
        int n_to;
        int start_c;
        int to_c;
        bit seen_wb;

        vecs[0]  = '{3'd0, 32'h0000FFFF, 32'h00000001, 5'd5,  32'h00000001, 2'b00, 32'h00010000, 1'b0, 0};
        vecs[1]  = '{3'd1, 32'h00000005, 32'h00000007, 5'd6,  32'hFFFFFFF9, 2'b00, 32'hFFFFFFFE, 1'b0, 0};
        vecs[2]  = '{3'd1, 32'h00000007, 32'h00000005, 5'd7,  32'hFFFFFFFB, 2'b00, 32'h00000002, 1'b1, 0};
        vecs[3]  = '{3'd5, 32'h00000003, 32'h00000007, 5'd8,  32'hFFFFFFF9, 2'b00, 32'h00000001, 1'b0, 0};
        vecs[4]  = '{3'd5, 32'h00000007, 32'h00000003, 5'd9,  32'hFFFFFFFD, 2'b00, 32'h00000000, 1'b0, 0};
        vecs[5]  = '{3'd5, 32'h00000000, 32'h00000000, 5'd10, 32'h00000000, 2'b00, 32'h00000000, 1'b0, 0};
        vecs[6]  = '{3'd5, 32'hFFFFFFFF, 32'h00000000, 5'd11, 32'h00000000, 2'b00, 32'h00000000, 1'b0, 0};
        vecs[7]  = '{3'd2, 32'hF0F0A5A5, 32'h0FF0FFFF, 5'd12, 32'h0FF0FFFF, 2'b01, 32'h00F0A5A5, 1'b0, 0};
        vecs[8]  = '{3'd3, 32'hF0F0A5A5, 32'h0FF0FFFF, 5'd13, 32'h0FF0FFFF, 2'b10, 32'hFFF0FFFF, 1'b0, 0};
        vecs[9]  = '{3'd4, 32'hF0F0A5A5, 32'h0FF0FFFF, 5'd14, 32'h0FF0FFFF, 2'b11, 32'hFF005A5A, 1'b0, 3};
        vecs[10] = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 5'd31, 32'h00000001, 2'b00, 32'h00000000, 1'b1, 0};
        vecs[11] = '{3'd0, 32'h12345678, 32'h11111111, 5'd1,  32'h11111111, 2'b00, 32'h23456789, 1'b0, 4};

        i_rst_n       = 1'b0;
        i_issue_valid = 1'b0;
        i_issue_op    = 3'd0;
        i_rs1_data    = '0;
        i_rs2_data    = '0;
        i_rd_addr     = '0;
        i_wb_ready    = 1'b0;
        eng_en        = 1'b1;

        repeat (2) @(negedge i_clk);
        check("rst_issue_ready", o_issue_ready, 1);
        check("rst_alu_start", o_alu_start, 0);
        check("rst_stall_reset", o_alu_stall_reset, 0);
        check("rst_wb_valid", o_wb_valid, 0);
        check("rst_operand_two", o_alu_operand_two, 0);
        check("rst_wb_data", o_wb_data, 0);
        check("rst_err_illegal", o_err_illegal, 0);
        check("rst_err_timeout", o_err_timeout, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Illegal op: dropped with a single error pulse, engine untouched.
        @(posedge i_clk); #1;
        i_issue_valid = 1'b1;
        i_issue_op    = 3'b111;
        @(negedge i_clk);
        check("illegal_issue_ready", o_issue_ready, 1);
        @(posedge i_clk); #1;
        i_issue_valid = 1'b0;
        n_ill   = 0;
        n_start = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            if (c == 0) check("illegal_pulse_next_cycle", o_err_illegal, 1);
            if (o_err_illegal) n_ill++;
            if (o_alu_start) n_start++;
            check("illegal_ready_stays", o_issue_ready, 1);
        end
        check("illegal_pulse_count", n_ill, 1);
        check("illegal_no_start", n_start, 0);

        // Engine timeout: no data-valid at all.
        eng_en = 1'b0;
        @(posedge i_clk); #1;
        i_issue_valid = 1'b1;
        i_issue_op    = 3'd0;
        i_rs1_data    = 32'h1;
        i_rs2_data    = 32'h2;
        @(posedge i_clk); #1;
        i_issue_valid = 1'b0;
        start_c = -1;
        to_c    = -1;
        n_to    = 0;
        seen_wb = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge i_clk);
            if (o_alu_start && start_c < 0) start_c = c;
            if (o_err_timeout) begin
                n_to++;
                if (to_c < 0) begin
                    to_c = c;
                    check("timeout_stall_reset", o_alu_stall_reset, 1);
                end
            end
            if (o_wb_valid) seen_wb = 1'b1;
            if (to_c > 0 && c == to_c + 1) check("timeout_back_to_idle", o_issue_ready, 1);
        end
        check("timeout_distance", to_c - start_c, 8);
        check("timeout_pulse_count", n_to, 1);
        check("timeout_no_wb", seen_wb, 0);

        // Async reset while waiting on the engine.
        @(posedge i_clk); #1;
        i_issue_valid = 1'b1;
        i_issue_op    = 3'd1;
        i_rs1_data    = 32'h9;
        i_rs2_data    = 32'h4;
        @(posedge i_clk); #1;
        i_issue_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        check("midwait_ready_low", o_issue_ready, 0);
        i_rst_n = 1'b0;
        #1;
        check("async_rst_issue_ready", o_issue_ready, 1);
        check("async_rst_operand_two", o_alu_operand_two, 0);
        check("async_rst_stall_reset", o_alu_stall_reset, 0);
        check("async_rst_wb_valid", o_wb_valid, 0);
        check("async_rst_err_timeout", o_err_timeout, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        eng_en  = 1'b1;
        seen_wb = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (o_wb_valid || o_alu_start) seen_wb = 1'b1;
        end
        check("post_reset_no_activity", seen_wb, 0);

        run_vec(vecs[0]);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_alu_issue_ctrl.md
Name: rv32_alu_issue_ctrl

Overview:
- Initiator-side controller for the two-cycle, 16-bit-sliced ALU execute FSM.
- Accepts decoded ALU ops from decode over a valid/ready handshake and maps each onto the FSM's 2-bit select (ADD/AND/OR/XOR); SUB and SLTU are synthesised via operand negation.
- Starts the engine, waits for data-valid, captures result/carry and releases the engine's hold.
- Presents the result to writeback over a valid/ready handshake. It sits between decode and the ALU FSM in the execute stage.

Parameters:
- TIMEOUT_CYCLES, 8, cycles in WAIT without engine data-valid before an abort; range 3..255.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_issue_valid  in  1  decode presents an op
- o_issue_ready  out  1  controller can accept an op (high only in IDLE)
- i_issue_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLTU; 110/111 illegal
- i_rs1_data  in  32  operand one
- i_rs2_data  in  32  operand two
- i_rd_addr  in  5  destination register
- o_alu_start  out  1  one-cycle pulse; restarts engine phase counter
- o_alu_operand_one  out  32  engine operand one (registered, stable ISSUE..RELEASE)
- o_alu_operand_two  out  32  engine operand two (registered)
- o_alu_sel  out  2  00 add, 01 and, 10 or, 11 xor
- o_alu_stall_reset  out  1  high one cycle in RELEASE to clear engine hold
- i_alu_data_valid  in  1  engine result valid
- i_alu_result  in  32  engine result
- i_alu_carry_out  in  1  engine carry out of bit 31
- o_wb_valid  out  1  result available to writeback
- i_wb_ready  in  1  writeback accepts
- o_wb_rd_addr  out  5  destination register
- o_wb_data  out  32  final result
- o_wb_carry  out  1  captured carry (ADD/SUB only, else 0)
- o_err_illegal  out  1  one-cycle pulse: illegal op dropped
- o_err_timeout  out  1  one-cycle pulse: engine timeout abort

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All outputs 0 except o_issue_ready=1. Operand/result registers cleared; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, RELEASE, WB.
- IDLE: if i_issue_valid & o_issue_ready:
  - Legal op: latch rs1, operand two, rd, op; go to ISSUE.
  - Illegal op: pulse o_err_illegal next cycle; stay IDLE; no engine activity.
- Operand two mapping: SUB/SLTU latch two's-complement negation of rs2 (~rs2+1, mod 2^32); all other ops latch rs2 unchanged.
- o_alu_sel mapping: ADD/SUB/SLTU give 00; AND 01; OR 10; XOR 11.
- ISSUE (1 cycle): o_alu_start=1; counter cleared; go to WAIT.
- WAIT: counter increments each cycle.
  - On i_alu_data_valid: capture result and carry; go to RELEASE.
  - Counter reaching TIMEOUT_CYCLES without valid: pulse o_err_timeout, drive o_alu_stall_reset for that cycle, discard op, go to IDLE.
  - Valid and timeout in the same cycle: valid wins.
- RELEASE (1 cycle): o_alu_stall_reset=1; compute the final result into the WB registers; go to WB.
  - SLTU result = 1 if rs2!=0 and captured carry==0, else 0; o_wb_carry=0.
  - AND/OR/XOR: o_wb_carry=0.
- WB: o_wb_valid=1; rd/data/carry held stable until i_wb_ready; on the handshake go to IDLE next cycle.
- Latency: ISSUE→WB is 3 cycles plus engine latency. With a 2-cycle engine, an op accepted at cycle T gives o_wb_valid at T+5 (ISSUE T+1, WAIT T+2..T+3, RELEASE T+4).
- i_alu_data_valid outside WAIT is ignored.
- Async reset mid-op aborts immediately; nothing reaches writeback.

Test Plan:
- ADD 0x0000FFFF + 0x00000001, rd=5 -> o_wb_data=0x00010000, carry=0, rd=5; o_alu_start one pulse; o_alu_stall_reset one pulse.
- SUB 5 - 7 -> o_alu_operand_two=0xFFFFFFF9, o_wb_data=0xFFFFFFFE; SUB 7 - 5 -> 0x00000002, carry=1.
- SLTU: (3,7) -> 1; (7,3) -> 0; (0,0) -> 0; (0xFFFFFFFF,0) -> 0.
- Logic ops on 0xF0F0A5A5 and 0x0FF0FFFF: AND 0x00F0A5A5, OR 0xFFF0FFFF, XOR 0xFF005A5A; each sel mapped correctly.
- Illegal op 111 -> o_err_illegal one pulse, no o_alu_start, o_issue_ready stays 1. Engine never asserts valid -> o_err_timeout exactly 8 cycles after ISSUE, then IDLE.
- Writeback backpressure: i_wb_ready low 4 cycles -> o_wb_* stable, o_issue_ready=0. Reset asserted mid-WAIT -> all outputs to reset values immediately.
